// File: rtl/multimode_mod_counter.sv
`default_nettype none
// ============================================================================
// Module      : multimode_mod_counter
// Description : WIDTH-bit up/down counter, full-range or runtime modulus,
//               with load, enable, registered wrap pulse and wrap counter.
// Revision    : 1.0 - initial release
// ============================================================================
module multimode_mod_counter #(
    parameter int WIDTH  = 4,
    parameter int WRAP_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              s0,
    input  logic              s1,
    input  logic [WIDTH-1:0]  modulus,
    input  logic              en,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              wraps_clr,
    output logic [WIDTH-1:0]  q,
    output logic              tc,
    output logic [WRAP_W-1:0] wraps
);

    localparam logic [WIDTH-1:0]  C_ALL_ONES = '1;
    localparam logic [WIDTH-1:0]  C_ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]  C_ZERO     = '0;
    localparam logic [WRAP_W-1:0] C_WRAP_MAX = '1;
    localparam logic [WRAP_W-1:0] C_WRAP_ONE = {{(WRAP_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]  w_top;
    logic              w_wrap;
    logic [WIDTH-1:0]  count_q, count_d;
    logic              tc_q, tc_d;
    logic [WRAP_W-1:0] wraps_q, wraps_d;

    // A zero modulus selects the full 2^WIDTH range.
    always_comb begin
        w_top = C_ALL_ONES;
        if (s1 && (modulus != C_ZERO)) begin
            w_top = modulus - C_ONE;
        end
    end

    always_comb begin
        count_d = count_q;
        w_wrap  = 1'b0;
        if (load) begin
            count_d = load_val;
        end else if (en) begin
            if (!s0) begin
                // Out-of-range values fold back to zero as a wrap.
                if (count_q >= w_top) begin
                    count_d = C_ZERO;
                    w_wrap  = 1'b1;
                end else begin
                    count_d = count_q + C_ONE;
                end
            end else begin
                // Out-of-range values clamp to TOP without counting a wrap.
                if (count_q == C_ZERO) begin
                    count_d = w_top;
                    w_wrap  = 1'b1;
                end else if (count_q > w_top) begin
                    count_d = w_top;
                end else begin
                    count_d = count_q - C_ONE;
                end
            end
        end
    end

    always_comb begin
        tc_d    = w_wrap;
        wraps_d = wraps_q;
        if (wraps_clr) begin
            wraps_d = '0;
        end else if (w_wrap && (wraps_q != C_WRAP_MAX)) begin
            wraps_d = wraps_q + C_WRAP_ONE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            wraps_q <= '0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            wraps_q <= wraps_d;
        end
    end

    assign q     = count_q;
    assign tc    = tc_q;
    assign wraps = wraps_q;

endmodule
`default_nettype wire

// File: doc/multimode_mod_counter.md
Name: multimode_mod_counter

Overview:
Parametrised successor to the team's 2-bit mode-select counter. A WIDTH-bit counter with four modes: up or down, over the full 2^WIDTH range or over a runtime-programmable modulus. It adds count enable, synchronous parallel load, a registered terminal-count pulse and a saturating wrap-event counter. It is used as a general sequencer/divider wherever the fixed mod-4/mod-3 counter was previously instantiated.

Parameters:
WIDTH, 4, counter width in bits (>= 2)
WRAP_W, 8, width of the saturating wrap-event counter (>= 1)

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
s0  input  1  mode select LSB: 0 = up, 1 = down
s1  input  1  mode select MSB: 0 = full range (mod 2^WIDTH), 1 = mod M
modulus  input  WIDTH  M for s1=1, sampled every edge; 0 means 2^WIDTH
en  input  1  count enable
load  input  1  synchronous load strobe
load_val  input  WIDTH  value loaded when load=1
q  output  WIDTH  current count (registered)
tc  output  1  one-cycle pulse, registered, flags a wrap on the previous edge
wraps  output  WRAP_W  number of wraps since reset, saturates at all-ones
wraps_clr  input  1  synchronous clear of wraps

Behaviour:
- Reset (reset=0, asynchronous): q=0, tc=0, wraps=0 immediately. They stay so until the first rising edge after release.
- Let TOP = 2^WIDTH-1 when s1=0 or modulus=0. Otherwise TOP = modulus-1.
- Priority per edge: load > en > hold.
- load=1: q <= load_val unchanged, even if load_val > TOP. tc <= 0. No wrap is counted.
- en=1, load=0, up (s0=0):
  - q==TOP: q <= 0, wrap event.
  - q>TOP (out of range): q <= 0, wrap event.
  - otherwise: q <= q+1.
- en=1, load=0, down (s0=1):
  - q==0: q <= TOP, wrap event.
  - q>TOP: q <= TOP, not a wrap.
  - otherwise: q <= q-1.
- en=0, load=0: q holds, tc <= 0.
- modulus=1 with s1=1: TOP=0. Up and down both hold q at 0, and every enabled edge is a wrap event.
- Mode or modulus may change on any cycle. The new values apply to the next edge; no history is kept.
- tc <= 1 on an edge where a wrap event occurs, else 0. It is never asserted two cycles running unless wraps occur on consecutive edges.
- wraps update on each edge:
  - wraps_clr=1: wraps <= 0. Clear wins over a simultaneous wrap event.
  - Otherwise, on a wrap event: wraps <= wraps+1, saturating at 2^WRAP_W-1.
- Arithmetic is unsigned, WIDTH bits, with no carry-out. TOP is computed in WIDTH bits (modulus=0 gives all-ones).
- Latency: q, tc and wraps are all updated on the same edge as the triggering inputs. There are no combinational paths from inputs to outputs.
- Reset asserted mid-count clears all state asynchronously. Load or count on the release edge proceeds normally.

Test Plan:
- Full-range up (WIDTH=4, s1s0=00, en=1) from reset, 16 edges -> q = 1..15 then 0; tc high only in the cycle after q 15->0; wraps=1.
- Full-range down (s1s0=01) from q=0, 3 edges -> q = 15, 14, 13; tc pulse after the first edge; wraps increments by 1.
- Mod-M up (s1s0=10, modulus=3) from q=0 -> 1, 2, 0, 1; then load 9 and count up -> q=9, then 0 with tc=1.
- Mod-M down (s1s0=11, modulus=3):
  - from q=0 -> 2, 1, 0, 2;
  - load 9, then one down edge -> q=2 with tc=0.
- Modulus edge cases:
  - modulus=1 -> q stays 0 and tc stays high every enabled edge;
  - modulus=0 behaves identically to s1=0.
- Control and saturation (WRAP_W=2):
  - en=0 holds q and keeps tc low;
  - load and en together -> load wins;
  - 5 wraps -> wraps=3 (saturated);
  - wraps_clr on a wrap edge -> wraps=0;
  - reset pulled low between edges -> q, tc, wraps go to 0 without a clock edge.
